// File: rtl/alu_pkg.sv
// Shared opcode constants and LFSR helpers for the execute-stage ALU.
package alu_pkg;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam logic [31:0] ALU_DEFAULT_SEED = 32'h0000_0001;

    // Fibonacci step for x^32 + x^22 + x^2 + x + 1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] q);
        return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
    endfunction

endpackage

// File: rtl/exec_alu_rng_if.sv
// Operand/result bundle between the execute-stage control and the ALU core.
interface exec_alu_rng_if;

    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  alu_opcode;
    logic [4:0]  shamt;
    logic [31:0] alu_result;
    logic        is_not_equal;
    logic        is_less_than;
    logic        overflow;
    logic [31:0] random_val;

    modport master (
        output operand_a, operand_b, alu_opcode, shamt,
        input  alu_result, is_not_equal, is_less_than, overflow, random_val
    );

    modport slave (
        input  operand_a, operand_b, alu_opcode, shamt,
        output alu_result, is_not_equal, is_less_than, overflow, random_val
    );

endinterface

// File: rtl/exec_alu_rng_add32_core.sv
// 32-bit adder with signed-overflow and compare flags; subtract by feeding ~b and cin=1.
module add32_core (
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    input  logic               cin,
    output logic signed [31:0] sum,
    output logic               overflow,
    output logic               is_not_equal,
    output logic               is_less_than
);

    assign sum          = a + b + {31'd0, cin};
    assign overflow     = (a[31] == b[31]) && (sum[31] != a[31]);
    assign is_not_equal = (sum != 32'sd0);
    // Sign of a wrapped difference is inverted, so fold the overflow back in.
    assign is_less_than = sum[31] ^ overflow;

endmodule

// File: rtl/exec_alu_rng.sv
// Execute-stage core: combinational ALU with branch-compare flags plus a free-running LFSR.
module exec_alu_rng
    import alu_pkg::*;
#(
    parameter logic [31:0] RAND_SEED = ALU_DEFAULT_SEED
) (
    input  logic           clock,
    input  logic           reset,
    exec_alu_rng_if.slave  alu
);

    logic signed [31:0] op_a;
    logic signed [31:0] op_b;
    logic signed [31:0] sub_diff;
    logic               sub_ovf;
    logic               cmp_ne;
    logic               cmp_lt;
    logic signed [31:0] add_sum;
    logic               add_ovf;
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] prod;
    logic               mul_ovf;
    logic               div_by_zero;
    logic               div_min_neg1;
    logic signed [31:0] div_den;
    logic signed [31:0] div_quot;
    logic signed [31:0] result;
    logic               ovf;

    assign op_a = alu.operand_a;
    assign op_b = alu.operand_b;

    // Always subtracting so branch flags are valid whatever the opcode.
    add32_core u_sub (
        .a            (op_a),
        .b            (~op_b),
        .cin          (1'b1),
        .sum          (sub_diff),
        .overflow     (sub_ovf),
        .is_not_equal (cmp_ne),
        .is_less_than (cmp_lt)
    );

    assign add_sum = op_a + op_b;
    assign add_ovf = (op_a[31] == op_b[31]) && (add_sum[31] != op_a[31]);

    assign a_ext   = {{32{op_a[31]}}, op_a};
    assign b_ext   = {{32{op_b[31]}}, op_b};
    assign prod    = a_ext * b_ext;
    assign mul_ovf = !((&prod[63:31]) || !(|prod[63:31]));

    // Divisor is steered to 1 on the two exceptional cases so the divider never sees them.
    assign div_by_zero  = (op_b == 32'sd0);
    assign div_min_neg1 = (op_a == 32'sh8000_0000) && (op_b == -32'sd1);
    assign div_den      = (div_by_zero || div_min_neg1) ? 32'sd1 : op_b;
    assign div_quot     = op_a / div_den;

    always_comb begin
        result = 32'sd0;
        ovf    = 1'b0;
        case (alu.alu_opcode)
            ALU_ADD: begin
                result = add_sum;
                ovf    = add_ovf;
            end
            ALU_SUB: begin
                result = sub_diff;
                ovf    = sub_ovf;
            end
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_SLL: result = op_a << alu.shamt;
            ALU_SRA: result = op_a >>> alu.shamt;
            ALU_MUL: begin
                result = prod[31:0];
                ovf    = mul_ovf;
            end
            ALU_DIV: begin
                result = div_by_zero ? 32'sd0 : div_quot;
                ovf    = div_by_zero || div_min_neg1;
            end
            default: begin
                result = 32'sd0;
                ovf    = 1'b0;
            end
        endcase
    end

    assign alu.alu_result   = result;
    assign alu.overflow     = ovf;
    assign alu.is_not_equal = cmp_ne;
    assign alu.is_less_than = cmp_lt;

    logic [1:0]  rst_sync;
    logic [31:0] lfsr_q;

    // Reset asserts asynchronously; its release reaches the LFSR through two flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= RAND_SEED;
        end else if (rst_sync[1]) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign alu.random_val = lfsr_q;

endmodule

// File: tb/tb_exec_alu_rng.sv
// Directed-vector bench for exec_alu_rng with a queue-based scoreboard and negedge monitor.
module tb_exec_alu_rng;
    import alu_pkg::*;

    typedef struct packed {
        logic [4:0]  chk;   // {rng, lt, ne, ovf, res}
        logic [31:0] res;
        logic        ovf;
        logic        ne;
        logic        lt;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic stim_vld = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    exp_t  sb_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_nm;

    always #5 clock = ~clock;

    exec_alu_rng_if intf ();

    exec_alu_rng #(.RAND_SEED(32'h0000_0001)) dut (
        .clock (clock),
        .reset (reset),
        .alu   (intf)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (stim_vld) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL scoreboard: output presented with no expected entry");
            end else begin
                mon_e  = sb_q.pop_front();
                mon_nm = name_q.pop_front();
                if (mon_e.chk[4]) cmp({mon_nm, ".rng"}, intf.random_val, mon_e.res);
                if (mon_e.chk[0]) cmp({mon_nm, ".res"}, intf.alu_result, mon_e.res);
                if (mon_e.chk[1]) cmp({mon_nm, ".ovf"}, {31'd0, intf.overflow}, {31'd0, mon_e.ovf});
                if (mon_e.chk[2]) cmp({mon_nm, ".ne"}, {31'd0, intf.is_not_equal}, {31'd0, mon_e.ne});
                if (mon_e.chk[3]) cmp({mon_nm, ".lt"}, {31'd0, intf.is_less_than}, {31'd0, mon_e.lt});
            end
        end
    end

    task automatic push(input string nm, input logic [4:0] chk, input logic [31:0] res,
                        input logic ovf, input logic ne, input logic lt);
        exp_t e;
        e.chk = chk;
        e.res = res;
        e.ovf = ovf;
        e.ne  = ne;
        e.lt  = lt;
        sb_q.push_back(e);
        name_q.push_back(nm);
        stim_vld = 1'b1;
    endtask

    task automatic alu_vec(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic [4:0] sh, input logic [31:0] res,
                           input logic ovf, input logic ne, input logic lt);
        @(posedge clock);
        #1;
        intf.operand_a  = a;
        intf.operand_b  = b;
        intf.alu_opcode = op;
        intf.shamt      = sh;
        push(nm, 5'b01111, res, ovf, ne, lt);
    endtask

    task automatic rng_vec(input string nm, input logic [31:0] exp);
        @(posedge clock);
        #1;
        push(nm, 5'b10000, exp, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
        stim_vld = 1'b0;
    endtask

    task automatic release_and_check(input string tag);
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            if (intf.random_val != 32'h0000_0001) break;
        end
        push({tag, "_1"}, 5'b10000, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        rng_vec({tag, "_2"}, 32'h0000_0006);
        rng_vec({tag, "_3"}, 32'h0000_000D);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset           = 1'b1;
        intf.operand_a  = '0;
        intf.operand_b  = '0;
        intf.alu_opcode = '0;
        intf.shamt      = '0;
        #2 reset = 1'b0;

        rng_vec("rng_seed", 32'h0000_0001);

        //          name          A             B             op       sh    result        ovf  ne   lt
        alu_vec("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD, 5'd0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        alu_vec("add_neg",    32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_ADD, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        alu_vec("sub_neg",    32'hFFFF_FFFB, 32'h0000_0003, ALU_SUB, 5'd0, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1);
        alu_vec("sub_eq",     32'h0000_0007, 32'h0000_0007, ALU_SUB, 5'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        alu_vec("sub_wrap",   32'h8000_0000, 32'h0000_0001, ALU_SUB, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
        alu_vec("sub_povf",   32'h7FFF_FFFF, 32'hFFFF_FFFF, ALU_SUB, 5'd0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        alu_vec("and",        32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND, 5'd0, 32'hF000_F000, 1'b0, 1'b1, 1'b1);
        alu_vec("or",         32'hF0F0_F0F0, 32'hFF00_FF00, ALU_OR,  5'd0, 32'hFFF0_FFF0, 1'b0, 1'b1, 1'b1);
        alu_vec("sll",        32'h8000_00F0, 32'h0000_0000, ALU_SLL, 5'd4, 32'h0000_0F00, 1'b0, 1'b1, 1'b1);
        alu_vec("sra",        32'h8000_00F0, 32'h0000_0000, ALU_SRA, 5'd4, 32'hF800_000F, 1'b0, 1'b1, 1'b1);
        alu_vec("mul_ovf",    32'h0001_0000, 32'h0001_0000, ALU_MUL, 5'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        alu_vec("mul_neg",    32'hFFFF_FFFD, 32'h0000_0004, ALU_MUL, 5'd0, 32'hFFFF_FFF4, 1'b0, 1'b1, 1'b1);
        alu_vec("mul_min",    32'h0000_8000, 32'hFFFF_0000, ALU_MUL, 5'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        alu_vec("div_trunc",  32'hFFFF_FFF9, 32'h0000_0002, ALU_DIV, 5'd0, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b1);
        alu_vec("div_zero",   32'h0000_0005, 32'h0000_0000, ALU_DIV, 5'd0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        alu_vec("div_minneg", 32'h8000_0000, 32'hFFFF_FFFF, ALU_DIV, 5'd0, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
        alu_vec("bad_op",     32'hF0F0_F0F0, 32'hFF00_FF00, 5'b11111, 5'd3, 32'h0000_0000, 1'b0, 1'b1, 1'b1);

        rng_vec("rng_seed_hold", 32'h0000_0001);
        idle();

        release_and_check("rng_run");

        // Assert reset between edges; the seed must reappear before the next edge.
        @(posedge clock);
        #1;
        stim_vld = 1'b0;
        #2 reset = 1'b0;
        #1 push("rng_async_reset", 5'b10000, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        idle();

        release_and_check("rng_restart");
        idle();
        @(posedge clock);

        if (sb_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
